// File: rtl/csi_link_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : csi_link_burst_scheduler
// Purpose  : Round-robin HS burst sequencer sharing one D-PHY link between
//            CSI packet sources, with inter-burst gap and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module csi_link_burst_scheduler #(
    parameter int N_REQ      = 4,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   hs_tx_word_clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] burst_len,
    input  logic                   stop_state,
    input  logic                   tx_ready_hs,
    input  logic                   err_clr,
    output logic [N_REQ-1:0]       grant,
    output logic [LEN_W-1:0]       burst_size,
    output logic                   tx_request_hs,
    output logic                   pop,
    output logic                   done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_STOP = 3'd1;
    localparam logic [2:0] c_BURST     = 3'd2;
    localparam logic [2:0] c_DRAIN     = 3'd3;
    localparam logic [2:0] c_GAP       = 3'd4;
    localparam logic [2:0] c_ERR       = 3'd5;

    logic [2:0]         r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [LEN_W-1:0]   r_burst_size;
    logic [LEN_W-1:0]   r_wcnt;
    logic [c_WD_W-1:0]  r_wdog;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_tx_request_hs;
    logic               r_done;
    logic               r_timeout_err;
    logic               r_seen_low;

    logic               w_pop;
    logic               w_found;
    logic [c_IDX_W-1:0] w_sel;
    logic [N_REQ-1:0]   w_elig;
    logic [LEN_W-1:0]   w_len  [N_REQ];
    logic [c_IDX_W-1:0] w_cand [N_REQ];
    logic [LEN_W-1:0]   w_wcnt_nxt;
    logic               w_wd_hit;

    assign w_pop      = r_tx_request_hs & tx_ready_hs;
    assign w_wcnt_nxt = r_wcnt + LEN_W'(1);
    assign w_wd_hit   = (r_wdog == c_WD_LAST);

    for (genvar i = 0; i < N_REQ; i++) begin : g_elig
        assign w_len[i]  = burst_len[i*LEN_W +: LEN_W];
        assign w_elig[i] = req[i] & (|w_len[i]);
    end

    // Candidate k is (rr_ptr + k) mod N_REQ, so the search order rotates.
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        logic [c_IDX_W:0] w_sum;
        assign w_sum     = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
        assign w_cand[k] = (w_sum >= (c_IDX_W+1)'(N_REQ))
                         ? c_IDX_W'(w_sum - (c_IDX_W+1)'(N_REQ))
                         : w_sum[c_IDX_W-1:0];
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_elig[w_cand[k]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[k];
            end
        end
    end

    always_ff @(posedge hs_tx_word_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_grant         <= '0;
            r_idx           <= '0;
            r_rr_ptr        <= '0;
            r_burst_size    <= '0;
            r_wcnt          <= '0;
            r_wdog          <= '0;
            r_gap_cnt       <= '0;
            r_tx_request_hs <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_seen_low      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
                        r_idx        <= w_sel;
                        r_burst_size <= w_len[w_sel];
                        r_wcnt       <= '0;
                        r_wdog       <= '0;
                        r_state      <= c_WAIT_STOP;
                    end
                end
                c_WAIT_STOP: begin
                    if (stop_state) begin
                        r_tx_request_hs <= 1'b1;
                        r_wdog          <= '0;
                        r_state         <= c_BURST;
                    end else if (w_wd_hit) begin
                        r_tx_request_hs <= 1'b0;
                        r_grant         <= '0;
                        r_timeout_err   <= 1'b1;
                        r_wdog          <= '0;
                        r_state         <= c_ERR;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end
                c_BURST: begin
                    // A pop takes priority over a coincident watchdog expiry.
                    if (w_pop) begin
                        r_wcnt <= w_wcnt_nxt;
                        r_wdog <= '0;
                        if (w_wcnt_nxt == r_burst_size) begin
                            r_tx_request_hs <= 1'b0;
                            r_seen_low      <= 1'b0;
                            r_state         <= c_DRAIN;
                        end
                    end else if (w_wd_hit) begin
                        r_tx_request_hs <= 1'b0;
                        r_grant         <= '0;
                        r_timeout_err   <= 1'b1;
                        r_wdog          <= '0;
                        r_state         <= c_ERR;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end
                c_DRAIN: begin
                    if (r_seen_low && stop_state) begin
                        r_done    <= 1'b1;
                        r_grant   <= '0;
                        r_rr_ptr  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
                        r_wdog    <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
                    end else if (w_wd_hit) begin
                        r_grant       <= '0;
                        r_timeout_err <= 1'b1;
                        r_wdog        <= '0;
                        r_state       <= c_ERR;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                        if (!stop_state) begin
                            r_seen_low <= 1'b1;
                        end
                    end
                end
                c_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                c_ERR: begin
                    if (err_clr) begin
                        r_timeout_err <= 1'b0;
                        r_state       <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign burst_size    = r_burst_size;
    assign tx_request_hs = r_tx_request_hs;
    assign pop           = w_pop;
    assign done          = r_done;
    assign busy          = (r_state != c_IDLE);
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire
